// File: rtl/score_glyph_encoder.sv
// Sequential double-dabble binary-to-glyph encoder with start/busy/done handshake.
// Define SCORE_GLYPH_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
module score_glyph_encoder #(
  parameter int unsigned VALUE_W = 16,
  parameter int unsigned DIGITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [VALUE_W-1:0]    value,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [8*DIGITS-1:0]   glyphs
);

  // Nibbles needed to hold 2^VALUE_W-1; widened to DIGITS so every digit has a nibble.
  localparam int unsigned BcdNib = (VALUE_W * 30103 + 99999) / 100000 + 1;
  localparam int unsigned NumNib = (BcdNib > DIGITS) ? BcdNib : DIGITS;
  localparam int unsigned CntW   = $clog2(VALUE_W + 1);

  localparam logic [7:0] GlyphBlank = 8'd34;
  localparam logic [7:0] GlyphDash  = 8'd36;

  typedef enum logic [1:0] {StIdle, StShift, StFormat} state_e;

  state_e                state_q, state_d;
  logic [4*NumNib-1:0]   bcd_q, bcd_d;
  logic [VALUE_W-1:0]    bin_q, bin_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic [8*DIGITS-1:0]   glyphs_q, glyphs_d;

  logic [4*NumNib-1:0]   bcd_adj;
  logic                  ovf_fmt;
  logic [8*DIGITS-1:0]   glyphs_fmt;

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(NumNib); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
`ifdef SCORE_GLYPH_LZ_BLANK_EN
    logic lead;
`endif
    ovf_fmt    = 1'b0;
    glyphs_fmt = '0;
    for (int k = int'(DIGITS); k < int'(NumNib); k++) begin
      if (bcd_q[4*k +: 4] != 4'd0) begin
        ovf_fmt = 1'b1;
      end
    end
    for (int k = 0; k < int'(DIGITS); k++) begin
      glyphs_fmt[8*k +: 8] = {4'd0, bcd_q[4*k +: 4]};
    end
`ifdef SCORE_GLYPH_LZ_BLANK_EN
    lead = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      if (bcd_q[4*k +: 4] != 4'd0) begin
        lead = 1'b0;
      end
      if (lead) begin
        glyphs_fmt[8*k +: 8] = GlyphBlank;
      end
    end
`endif
    if (ovf_fmt) begin
      glyphs_fmt = {DIGITS{GlyphDash}};
    end
  end

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    glyphs_d = glyphs_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = CntW'(VALUE_W);
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        {bcd_d, bin_d} = {bcd_adj[4*NumNib-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StFormat;
        end
      end
      StFormat: begin
        glyphs_d = glyphs_fmt;
        ovf_d    = ovf_fmt;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      bcd_q    <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      glyphs_q <= {DIGITS{GlyphBlank}};
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      glyphs_q <= glyphs_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign glyphs   = glyphs_q;

endmodule
